// File: rtl/pipe_stage.sv
// Pipeline register stage with flush/stall control and saturating stall/flush statistics.
// Flush beats stall beats load; a bubble always carries an all-zero control bundle.
module pipe_stage #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 32,
  parameter int NCH    = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  clr_cnt,
  input  logic                  in_valid,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int DW = NCH * DATA_W;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0]     data_q, data_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              stall_hit;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      // Operands are left in place; only validity and control are killed.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      ctrl_d  = in_valid ? in_ctrl : '0;
      data_d  = in_data;
    end
  end

  assign stall_hit = stall & ~flush & valid_q;

  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (clr_cnt) begin
      scnt_d = '0;
      fcnt_d = '0;
    end else begin
      if (stall_hit && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
      if (flush && (fcnt_q != '1))     fcnt_d = fcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: driver queues hand-computed expectations, monitor checks each edge.
module tb_pipe_stage;

  logic         clk, reset, stall, flush, clr_cnt, in_valid;
  logic [11:0]  in_ctrl;
  logic [127:0] in_data;
  logic         out_valid;
  logic [11:0]  out_ctrl;
  logic [127:0] out_data;
  logic [3:0]   stall_cnt, flush_cnt;

  pipe_stage #(.CTRL_W(12), .DATA_W(32), .NCH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    int           id;
    logic         v;
    logic [11:0]  c;
    logic [127:0] d;
    logic [3:0]   sc;
    logic [3:0]   fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vid   = 0;

  localparam logic [127:0] D1 = {32'hDEADBEEF, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] D2 = {32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0};
  localparam logic [127:0] D3 = {32'h0, 32'h0, 32'h0, 32'h00000055};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int id, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, id, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    cmp({nm, "_valid"}, -1, 128'(out_valid), 128'd0);
    cmp({nm, "_ctrl"},  -1, 128'(out_ctrl),  128'd0);
    cmp({nm, "_data"},  -1, out_data,        128'd0);
    cmp({nm, "_scnt"},  -1, 128'(stall_cnt), 128'd0);
    cmp({nm, "_fcnt"},  -1, 128'(flush_cnt), 128'd0);
  endtask

  task automatic vec(input logic st, input logic fl, input logic cl, input logic iv,
                     input logic [11:0] ic, input logic [127:0] id,
                     input logic ev, input logic [11:0] ec, input logic [127:0] ed,
                     input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(negedge clk);
    stall = st; flush = fl; clr_cnt = cl; in_valid = iv; in_ctrl = ic; in_data = id;
    e.id = vid; e.v = ev; e.c = ec; e.d = ed; e.sc = esc; e.fc = efc;
    q.push_back(e);
    vid++;
  endtask

  // Monitor: every edge that has a queued expectation is checked just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("valid", e.id, 128'(out_valid), 128'(e.v));
        cmp("ctrl",  e.id, 128'(out_ctrl),  128'(e.c));
        cmp("data",  e.id, out_data,        e.d);
        cmp("scnt",  e.id, 128'(stall_cnt), 128'(e.sc));
        cmp("fcnt",  e.id, 128'(flush_cnt), 128'(e.fc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    #2;
    chk_zero("reset0");
    @(negedge clk);
    reset = 1'b0;

    // load, stall x3 with new inputs, release
    vec(0,0,0,1,12'hABC,D1, 1,12'hABC,D1,4'd0,4'd0);
    vec(1,0,0,1,12'h123,D2, 1,12'hABC,D1,4'd1,4'd0);
    vec(1,0,0,1,12'h123,D2, 1,12'hABC,D1,4'd2,4'd0);
    vec(1,0,0,1,12'h123,D2, 1,12'hABC,D1,4'd3,4'd0);
    vec(0,0,0,1,12'h123,D2, 1,12'h123,D2,4'd3,4'd0);
    // flush beats stall, operands kept
    vec(0,0,0,1,12'h055,D3, 1,12'h055,D3,4'd3,4'd0);
    vec(1,1,0,1,12'h7FF,D1, 0,12'h000,D3,4'd3,4'd1);
    // bubble load, stall on bubble, flush on bubble
    vec(0,0,0,0,12'hFFF,D2, 0,12'h000,D2,4'd3,4'd1);
    vec(1,0,0,1,12'h456,D1, 0,12'h000,D2,4'd3,4'd1);
    vec(0,1,0,1,12'h456,D1, 0,12'h000,D2,4'd3,4'd2);
    // stall saturation
    vec(0,0,0,1,12'h5A5,D1, 1,12'h5A5,D1,4'd3,4'd2);
    for (int i = 0; i < 20; i++)
      vec(1,0,0,1,12'h777,D2, 1,12'h5A5,D1, (i + 4 > 15) ? 4'd15 : 4'(i + 4), 4'd2);
    // clear wins over a same-edge flush increment
    vec(0,1,1,1,12'h777,D2, 0,12'h000,D1,4'd0,4'd0);
    // flush saturation
    for (int i = 0; i < 17; i++)
      vec(0,1,0,1,12'hABC,D2, 0,12'h000,D1,4'd0, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    vec(0,0,0,1,12'h321,D2, 1,12'h321,D2,4'd0,4'd15);
    // clear wins over a same-edge stall increment
    vec(1,0,1,1,12'hABC,D1, 1,12'h321,D2,4'd0,4'd0);
    vec(0,0,0,1,12'hABC,D1, 1,12'hABC,D1,4'd0,4'd0);

    // async reset between edges, in the middle of a stall
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_zero("areset");
    @(posedge clk);
    #3;
    chk_zero("areset_hold");
    reset = 1'b0;
    vec(0,0,0,1,12'h321,D2, 1,12'h321,D2,4'd0,4'd0);
    vec(0,1,0,1,12'h321,D1, 0,12'h000,D2,4'd0,4'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    cmp("drain", -1, 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
